// File: rtl/core_lsu.sv
// core_lsu: memory stage. Drives the data-memory handshake, then aligns and extends load data.
// Optional macro CORE_LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating them.
module core_lsu #(
   parameter int XLEN        = 32,
   parameter int RSP_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            arst_ni,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_result_i,
   input  logic [XLEN-1:0] ex_wdata_i,
   input  logic [1:0]      ex_mem_op_i,
   input  logic [1:0]      ex_size_i,
   input  logic            ex_unsigned_i,
   input  logic [4:0]      ex_rd_addr_i,
   output logic            stall_o,
   output logic            data_mem_req_o,
   input  logic            data_mem_grnt_i,
   output logic [XLEN-1:0] data_mem_addr_o,
   output logic [XLEN-1:0] data_mem_wdata_o,
   output logic [3:0]      data_mem_be_o,
   output logic            data_mem_ren_o,
   output logic            data_mem_wen_o,
   input  logic [XLEN-1:0] data_mem_rdata_i,
   input  logic            data_mem_rvalid_i,
   output logic            wb_valid_o,
   output logic            wb_rd_we_o,
   output logic [4:0]      wb_rd_addr_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            bus_err_o,
   output logic            misaligned_o
);

   localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(RSP_TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

   state_t          r_state, w_state_d;
   logic [CW-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
   logic            r_load;
   logic [XLEN-1:0] r_addr;
   logic [1:0]      r_size;
   logic            r_uns;
   logic [4:0]      r_rd;
   logic [3:0]      r_be;
   logic [XLEN-1:0] r_wdata;
   logic            r_wb_valid, r_wb_we, r_bus_err;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;

   logic            w_is_mem, w_capture, w_wb_fire, w_wb_we, w_bus_err;
   logic [4:0]      w_wb_rd;
   logic [XLEN-1:0] w_wb_data;
   logic [1:0]      w_in_off, w_rsp_off;
   logic [3:0]      w_in_be;
   logic [XLEN-1:0] w_in_wdata, w_rsh, w_ext;

   // Byte lane offset of an access, truncated to the access's natural alignment.
   function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'b00:   lane_off = a;
         2'b01:   lane_off = {a[1], 1'b0};
         default: lane_off = 2'b00;
      endcase
   endfunction

   assign w_is_mem = (ex_mem_op_i == 2'b01) || (ex_mem_op_i == 2'b10);
   assign w_in_off = lane_off(ex_size_i, ex_result_i[1:0]);

   always_comb begin
      w_in_be    = 4'b1111;
      w_in_wdata = ex_wdata_i;
      case (ex_size_i)
         2'b00: begin
            w_in_be    = 4'b0001 << w_in_off;
            w_in_wdata = {4{ex_wdata_i[7:0]}};
         end
         2'b01: begin
            w_in_be    = 4'b0011 << w_in_off;
            w_in_wdata = {2{ex_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_rsp_off = lane_off(r_size, r_addr[1:0]);
   assign w_rsh     = data_mem_rdata_i >> {w_rsp_off, 3'b000};

   always_comb begin
      w_ext = w_rsh;
      case (r_size)
         2'b00:   w_ext = r_uns ? {{(XLEN-8){1'b0}}, w_rsh[7:0]}
                                : {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
         2'b01:   w_ext = r_uns ? {{(XLEN-16){1'b0}}, w_rsh[15:0]}
                                : {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
         default: ;
      endcase
   end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
   logic w_misal, w_misal_pulse, r_misal;
   assign w_misal = ((ex_size_i == 2'b01) && ex_result_i[0]) ||
                    (ex_size_i[1] && (ex_result_i[1:0] != 2'b00));
`endif

   assign w_cnt_inc = r_cnt + CW'(1);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_capture = 1'b0;
      w_wb_fire = 1'b0;
      w_wb_we   = 1'b0;
      w_wb_rd   = r_rd;
      w_wb_data = r_wb_data;
      w_bus_err = 1'b0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      w_misal_pulse = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (ex_valid_i) begin
               if (w_is_mem) begin
`ifdef CORE_LSU_MISALIGN_TRAP_EN
                  if (w_misal) begin
                     w_wb_fire     = 1'b1;
                     w_wb_rd       = ex_rd_addr_i;
                     w_misal_pulse = 1'b1;
                  end else begin
                     w_capture = 1'b1;
                     w_state_d = ST_REQ;
                  end
`else
                  w_capture = 1'b1;
                  w_state_d = ST_REQ;
`endif
               end else begin
                  // No memory op (including the reserved encoding): one-cycle pass-through.
                  w_wb_fire = 1'b1;
                  w_wb_we   = 1'b1;
                  w_wb_rd   = ex_rd_addr_i;
                  w_wb_data = ex_result_i;
               end
            end
         end
         ST_REQ: begin
            if (data_mem_grnt_i) begin
               if (r_load) begin
                  w_state_d = ST_RSP;
                  w_cnt_d   = '0;
               end else begin
                  w_state_d = ST_IDLE;
                  w_wb_fire = 1'b1;
               end
            end
         end
         ST_RSP: begin
            if (data_mem_rvalid_i) begin
               w_state_d = ST_IDLE;
               w_wb_fire = 1'b1;
               w_wb_we   = 1'b1;
               w_wb_data = w_ext;
            end else if ((RSP_TIMEOUT != 0) && (w_cnt_inc == TMO)) begin
               w_state_d = ST_IDLE;
               w_wb_fire = 1'b1;
               w_bus_err = 1'b1;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) r_state <= ST_IDLE;
      else          r_state <= w_state_d;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_cnt      <= '0;
         r_load     <= 1'b0;
         r_addr     <= '0;
         r_size     <= '0;
         r_uns      <= 1'b0;
         r_rd       <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_wb_valid <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_d;
         r_wb_valid <= w_wb_fire;
         r_wb_we    <= w_wb_fire & w_wb_we;
         r_bus_err  <= w_bus_err;
         if (w_capture) begin
            r_load  <= (ex_mem_op_i == 2'b01);
            r_addr  <= ex_result_i;
            r_size  <= ex_size_i;
            r_uns   <= ex_unsigned_i;
            r_rd    <= ex_rd_addr_i;
            r_be    <= w_in_be;
            r_wdata <= w_in_wdata;
         end
         if (w_wb_fire) begin
            r_wb_rd   <= w_wb_rd;
            r_wb_data <= w_wb_data;
         end
      end
   end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) r_misal <= 1'b0;
      else          r_misal <= w_misal_pulse;
   end
   assign misaligned_o = r_misal;
`else
   assign misaligned_o = 1'b0;
`endif

   assign stall_o          = (r_state != ST_IDLE);
   assign data_mem_req_o   = (r_state == ST_REQ);
   assign data_mem_ren_o   = data_mem_req_o & r_load;
   assign data_mem_wen_o   = data_mem_req_o & ~r_load;
   assign data_mem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
   assign data_mem_be_o    = r_be;
   assign data_mem_wdata_o = r_wdata;
   assign wb_valid_o       = r_wb_valid;
   assign wb_rd_we_o       = r_wb_we;
   assign wb_rd_addr_o     = r_wb_rd;
   assign wb_data_o        = r_wb_data;
   assign bus_err_o        = r_bus_err;

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: randomized self-checking bench for core_lsu against a lane-arithmetic reference model.
module tb_core_lsu;

   localparam int TMO = 16;

   logic        clk_i = 1'b0;
   logic        arst_ni;
   logic        ex_valid_i;
   logic [31:0] ex_result_i, ex_wdata_i;
   logic [1:0]  ex_mem_op_i, ex_size_i;
   logic        ex_unsigned_i;
   logic [4:0]  ex_rd_addr_i;
   logic        stall_o, data_mem_req_o, data_mem_grnt_i;
   logic [31:0] data_mem_addr_o, data_mem_wdata_o, data_mem_rdata_i;
   logic [3:0]  data_mem_be_o;
   logic        data_mem_ren_o, data_mem_wen_o, data_mem_rvalid_i;
   logic        wb_valid_o, wb_rd_we_o, bus_err_o, misaligned_o;
   logic [4:0]  wb_rd_addr_o;
   logic [31:0] wb_data_o;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   core_lsu #(.XLEN(32), .RSP_TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni),
      .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i), .ex_wdata_i(ex_wdata_i),
      .ex_mem_op_i(ex_mem_op_i), .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i),
      .ex_rd_addr_i(ex_rd_addr_i), .stall_o(stall_o),
      .data_mem_req_o(data_mem_req_o), .data_mem_grnt_i(data_mem_grnt_i),
      .data_mem_addr_o(data_mem_addr_o), .data_mem_wdata_o(data_mem_wdata_o),
      .data_mem_be_o(data_mem_be_o), .data_mem_ren_o(data_mem_ren_o),
      .data_mem_wen_o(data_mem_wen_o), .data_mem_rdata_i(data_mem_rdata_i),
      .data_mem_rvalid_i(data_mem_rvalid_i), .wb_valid_o(wb_valid_o),
      .wb_rd_we_o(wb_rd_we_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
      .bus_err_o(bus_err_o), .misaligned_o(misaligned_o)
   );

   function automatic logic [127:0] all_outs();
      return {stall_o, data_mem_req_o, data_mem_addr_o, data_mem_wdata_o, data_mem_be_o,
              data_mem_ren_o, data_mem_wen_o, wb_valid_o, wb_rd_we_o, wb_rd_addr_o,
              wb_data_o, bus_err_o, misaligned_o};
   endfunction

   // One instruction end to end; expectations come from byte-lane arithmetic.
   task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input int gd, input int rdl, input logic [31:0] rdata);
      int nb, off;
      bit is_mem, is_st, mis, trap;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_ld, mask;
      logic [127:0] got, exp;
      is_mem = (op == 2'b01) || (op == 2'b10);
      is_st  = (op == 2'b10);
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      off = (nb == 1) ? int'(addr[1:0]) : (nb == 2) ? 2 * int'(addr[1]) : 0;
      mis = ((nb == 2) && addr[0]) || ((nb == 4) && (addr[1:0] != 2'b00));
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      trap = is_mem && mis;
`else
      trap = 1'b0;
`endif
      e_be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      e_ld = rdata >> (8 * off);
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         e_ld = e_ld & mask;
         if (!uns && e_ld[8*nb-1]) e_ld = e_ld | ~mask;
      end

      ex_valid_i = 1'b1; ex_mem_op_i = op; ex_size_i = sz; ex_unsigned_i = uns;
      ex_result_i = addr; ex_wdata_i = wd; ex_rd_addr_i = rd;
      @(posedge clk_i); #1;
      ex_valid_i = 1'b0; ex_result_i = $urandom; ex_wdata_i = $urandom;
      ex_size_i = 2'($urandom); ex_unsigned_i = 1'($urandom); ex_rd_addr_i = 5'($urandom);

      if (!is_mem) begin
         n_chk++;
         got = {wb_valid_o, wb_rd_we_o, wb_rd_addr_o, wb_data_o, stall_o, data_mem_req_o};
         exp = {1'b1, 1'b1, rd, addr, 1'b0, 1'b0};
         if (got !== exp) $display("FAIL passthru: got %h want %h", got, exp);
         else n_pass++;
      end else if (trap) begin
         n_chk++;
         got = {data_mem_req_o, misaligned_o, wb_valid_o, wb_rd_we_o, stall_o};
         exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
         if (got !== exp) $display("FAIL misalign_trap: got %h want %h", got, exp);
         else n_pass++;
      end else begin
         for (int c = 0; c <= gd; c++) begin
            if (c > 0) begin @(posedge clk_i); #1; end
            n_chk++;
            got = {data_mem_req_o, data_mem_ren_o, data_mem_wen_o, stall_o, wb_valid_o,
                   data_mem_addr_o, data_mem_be_o, is_st ? data_mem_wdata_o : 32'h0};
            exp = {1'b1, !is_st, is_st, 1'b1, 1'b0, addr & ~32'd3, e_be, is_st ? e_wd : 32'h0};
            if (got !== exp) $display("FAIL req_bus: got %h want %h", got, exp);
            else n_pass++;
         end
         data_mem_grnt_i = 1'b1;
         @(posedge clk_i); #1;
         data_mem_grnt_i = 1'b0;
         if (is_st) begin
            n_chk++;
            got = {wb_valid_o, wb_rd_we_o, stall_o, data_mem_req_o};
            exp = {1'b1, 1'b0, 1'b0, 1'b0};
            if (got !== exp) $display("FAIL store_done: got %h want %h", got, exp);
            else n_pass++;
         end else begin
            n_chk++;
            got = {data_mem_req_o, data_mem_ren_o, data_mem_wen_o, stall_o, wb_valid_o};
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            if (got !== exp) $display("FAIL load_wait: got %h want %h", got, exp);
            else n_pass++;
            repeat (rdl) begin @(posedge clk_i); #1; end
            data_mem_rvalid_i = 1'b1; data_mem_rdata_i = rdata;
            @(posedge clk_i); #1;
            data_mem_rvalid_i = 1'b0; data_mem_rdata_i = $urandom;
            n_chk++;
            got = {wb_valid_o, wb_rd_we_o, wb_rd_addr_o, wb_data_o, stall_o};
            exp = {1'b1, 1'b1, rd, e_ld, 1'b0};
            if (got !== exp) $display("FAIL load_data: got %h want %h", got, exp);
            else n_pass++;
         end
      end
      @(posedge clk_i); #1;
      n_chk++;
      got = {wb_valid_o, wb_rd_we_o, bus_err_o, misaligned_o, stall_o, data_mem_req_o};
      exp = '0;
      if (got !== exp) $display("FAIL pulse_end: got %h want %h", got, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      arst_ni = 1'b0; ex_valid_i = 1'b0; ex_result_i = '0; ex_wdata_i = '0;
      ex_mem_op_i = '0; ex_size_i = '0; ex_unsigned_i = 1'b0; ex_rd_addr_i = '0;
      data_mem_grnt_i = 1'b0; data_mem_rdata_i = '0; data_mem_rvalid_i = 1'b0;
      #12;
      n_chk++;
      if (all_outs() !== '0) $display("FAIL reset_state: got %h want 0", all_outs());
      else n_pass++;
      arst_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_passthrough();
      run_op(2'b00, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 0, 0, 32'h0);
      run_op(2'b11, 2'b00, 1'b0, 32'hCAFE_F00D, 32'h0, 5'd31, 0, 0, 32'h0);
   endtask

   task automatic test_byte_store();
      run_op(2'b10, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd7, 3, 0, 32'h0);
   endtask

   task automatic test_half_load();
      run_op(2'b01, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd9, 1, 0, 32'h8001_0000);
      run_op(2'b01, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd9, 0, 2, 32'h8001_0000);
   endtask

   task automatic test_timeout();
      logic bad;
      logic [127:0] got, exp;
      ex_valid_i = 1'b1; ex_mem_op_i = 2'b01; ex_size_i = 2'b10; ex_unsigned_i = 1'b0;
      ex_result_i = 32'h0000_4000; ex_rd_addr_i = 5'd3;
      @(posedge clk_i); #1;
      ex_valid_i = 1'b0;
      data_mem_grnt_i = 1'b1;
      @(posedge clk_i); #1;
      data_mem_grnt_i = 1'b0;
      bad = !stall_o;
      for (int i = 1; i < TMO; i++) begin
         @(posedge clk_i); #1;
         if (bus_err_o || wb_valid_o || !stall_o) bad = 1'b1;
      end
      n_chk++;
      if (bad !== 1'b0) $display("FAIL timeout_early: got %b want 0", bad);
      else n_pass++;
      @(posedge clk_i); #1;
      n_chk++;
      got = {bus_err_o, wb_valid_o, wb_rd_we_o, stall_o};
      exp = {1'b1, 1'b1, 1'b0, 1'b0};
      if (got !== exp) $display("FAIL timeout_fire: got %h want %h", got, exp);
      else n_pass++;
      data_mem_rvalid_i = 1'b1; data_mem_rdata_i = 32'hDEAD_BEEF;
      @(posedge clk_i); #1;
      data_mem_rvalid_i = 1'b0;
      n_chk++;
      got = {bus_err_o, wb_valid_o, stall_o};
      exp = '0;
      if (got !== exp) $display("FAIL late_rvalid: got %h want %h", got, exp);
      else n_pass++;
      run_op(2'b01, 2'b00, 1'b0, 32'h0000_4001, 32'h0, 5'd4, 0, 1, 32'h0000_F100);
   endtask

   task automatic test_reset_mid();
      logic [127:0] got;
      ex_valid_i = 1'b1; ex_mem_op_i = 2'b01; ex_size_i = 2'b10;
      ex_result_i = 32'h0000_5000; ex_rd_addr_i = 5'd12;
      @(posedge clk_i); #1;
      ex_valid_i = 1'b0;
      data_mem_grnt_i = 1'b1;
      @(posedge clk_i); #1;
      data_mem_grnt_i = 1'b0;
      arst_ni = 1'b0;
      #1;
      n_chk++;
      if (all_outs() !== '0) $display("FAIL reset_mid: got %h want 0", all_outs());
      else n_pass++;
      #2 arst_ni = 1'b1;
      @(posedge clk_i); #1;
      data_mem_rvalid_i = 1'b1; data_mem_rdata_i = 32'h1111_2222;
      @(posedge clk_i); #1;
      data_mem_rvalid_i = 1'b0;
      n_chk++;
      got = {wb_valid_o, wb_rd_we_o, stall_o};
      if (got !== '0) $display("FAIL stray_rvalid: got %h want 0", got);
      else n_pass++;
      run_op(2'b00, 2'b00, 1'b0, 32'h0BAD_C0DE, 32'h0, 5'd1, 0, 0, 32'h0);
   endtask

   task automatic test_misalign();
      run_op(2'b01, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd6, 0, 0, 32'hA1B2_C3D4);
      run_op(2'b10, 2'b01, 1'b0, 32'h0000_3003, 32'h0000_BEEF, 5'd6, 1, 0, 32'h0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         run_op(2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                5'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), $urandom);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_byte_store();
      test_half_load();
      test_timeout();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Memory stage of the in-order core pipeline. Sits between core_execution and core_writeback.
- Consumes the ALU result (effective address), store data and rd address from execution.
- Issues the data-memory handshake, then aligns and sign- or zero-extends load data.
- Hands a registered result to writeback. Non-memory instructions pass straight through.

Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported.
- RSP_TIMEOUT, 16, maximum cycles to wait for data_mem_rvalid_i after a load grant; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- arst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  execution stage presents a valid instruction
- ex_result_i  in  32  ALU result; the effective address for loads and stores
- ex_wdata_i  in  32  store data (rs2)
- ex_mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_size_i  in  2  00 byte, 01 half, 10 word
- ex_unsigned_i  in  1  zero-extend loads
- ex_rd_addr_i  in  5  destination register
- stall_o  out  1  hold upstream stages
- data_mem_req_o  out  1  request
- data_mem_grnt_i  in  1  grant
- data_mem_addr_o  out  32  word-aligned address
- data_mem_wdata_o  out  32  replicated store data
- data_mem_be_o  out  4  byte enables
- data_mem_ren_o  out  1  read
- data_mem_wen_o  out  1  write
- data_mem_rdata_i  in  32  read data
- data_mem_rvalid_i  in  1  read data valid
- wb_valid_o  out  1  result valid to writeback
- wb_rd_we_o  out  1  write rd
- wb_rd_addr_o  out  5  rd address
- wb_data_o  out  32  rd data
- bus_err_o  out  1  one-cycle pulse on response timeout
- misaligned_o  out  1  one-cycle pulse on misaligned access

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_ni is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset mid-transaction: returns to IDLE immediately. An outstanding response is discarded and not forwarded.
- FSM states: IDLE, REQ, RSP.
- IDLE, accepting an instruction:
  - An instruction is accepted when ex_valid_i=1.
  - Mem op none: next cycle wb_valid_o=1, wb_rd_we_o=1, wb_data_o=ex_result_i, wb_rd_addr_o=ex_rd_addr_i. Latency 1, no stall.
  - Mem op load or store: capture address, size, unsigned flag, rd and aligned store data; go to REQ.
- REQ:
  - data_mem_req_o=1, ren or wen per op, addr={addr[31:2],2'b00}. Outputs stay stable until data_mem_grnt_i=1.
  - Grant on a store: next state IDLE; next cycle wb_valid_o=1, wb_rd_we_o=0.
  - Grant on a load: next state RSP; req, ren and wen drop the following cycle.
- RSP:
  - Wait for data_mem_rvalid_i, which arrives at least 1 cycle after grant.
  - On rvalid: next cycle wb_valid_o=1, wb_rd_we_o=1, wb_data_o=extended data; next state IDLE.
  - Timeout counter increments each RSP cycle. When it reaches RSP_TIMEOUT: bus_err_o=1 for one cycle, wb_valid_o=1, wb_rd_we_o=0, next state IDLE.
  - rvalid received outside RSP is ignored.
- stall_o = (state != IDLE). This is registered-state based. A new instruction is accepted in the first IDLE cycle.
- wb_valid_o is a single-cycle pulse. wb_rd_addr_o and wb_data_o hold their values until the next pulse.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load data:
  - rdata shifted right by addr[1:0]*8.
  - byte: bit 7 sign-extended, or zero-extended when unsigned.
  - half: bit 15 sign-extended, or zero-extended when unsigned.
  - word: unmodified.
- Misalignment is defined as: half with addr[0]=1, or word with addr[1:0]!=0.
- Size 11 is treated as word.

Optional Feature:
- Macro: CORE_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned mem op accepted in IDLE issues no bus request.
  - Next cycle misaligned_o=1 for one cycle, wb_valid_o=1, wb_rd_we_o=0. State remains IDLE.
- Undefined:
  - misaligned_o is tied 0.
  - Misaligned accesses are issued with byte enables and shift truncated to the access's natural alignment: half uses addr[1], word uses 4'b1111 and no shift.

Test Plan:
- Non-mem pass-through: ex_valid_i=1, op=00, result=32'h1234_5678, rd=5 -> next cycle wb_valid_o=1, wb_rd_we_o=1, wb_rd_addr_o=5, wb_data_o=32'h1234_5678; stall_o stays 0.
- Byte store: op=10, size=00, addr=32'h0000_1003, wdata=32'hAB -> req with addr=32'h0000_1000, be=4'b1000, wdata=32'hABAB_ABAB, wen=1. Grant held off 3 cycles: outputs stable and stall_o=1 throughout. One cycle after grant: wb_valid_o=1, wb_rd_we_o=0.
- Signed half load: addr=32'h2002, size=01, unsigned=0, rdata=32'h8001_0000 -> wb_data_o=32'hFFFF_8001. Same access with unsigned=1 -> wb_data_o=32'h0000_8001.
- Timeout: load granted, rvalid never asserted, RSP_TIMEOUT=16 -> bus_err_o pulses once after 16 RSP cycles, wb_rd_we_o=0, FSM back in IDLE. A later rvalid is ignored.
- Reset mid-transaction: arst_ni low while in RSP -> all outputs 0 immediately. After release, a stray rvalid produces no wb_valid_o.
- Misaligned word load at addr=32'h3001 with CORE_LSU_MISALIGN_TRAP_EN defined -> data_mem_req_o stays 0, misaligned_o and wb_valid_o pulse next cycle with wb_rd_we_o=0.
